leddc_scan_pwm: RTL

- Parametrised successor LED display driver with one clock domain.
- Accepts serial grey-scale frame data into a double-buffered (ping-pong) frame store.
- Swaps banks on Vsync only when a full frame has arrived.
- Drives CH PWM channel outputs and scans ROWS multiplexed rows, with per-row blanking and an optional half-resolution dithered mode.

---
 rtl/leddc_pkg.sv | 36 +++
 rtl/leddc_fbuf.sv | 66 ++++++
 rtl/leddc_scan_pwm.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/leddc_pkg.sv
// Shared types, constants and helpers for the scanned LED PWM driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package leddc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_PWM   = 2'd2
    } scan_state_e;

    localparam logic MODE_FULL = 1'b0;
    localparam logic MODE_HALF = 1'b1;

    // Ceiling log2, with clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Duty for one pixel. In half mode the dropped LSB is added back on
    // alternate frames, so two frames average to the full-resolution duty.
    function automatic logic [31:0] duty_calc(input logic [31:0] g,
                                              input logic        mode,
                                              input logic        round);
        if (mode == MODE_HALF) begin
            return (g >> 1) + {31'd0, g[0] & round};
        end
        return g;
    endfunction

endpackage

// File: rtl/leddc_fbuf.sv
// Ping-pong frame store: back bank takes pixel writes, front bank feeds one full row.
// Latency: write lands 1 cycle after we; row read is combinational; swap visible next cycle.
// Backpressure: none; the writer must not write while a swap is being requested.
//
// Ports:
//   GCK, rst        clock, synchronous active-high reset (clears bank select only)
//   swap            exchange front and back banks
//   we, wrow, wch,  write one GW-bit pixel into the back bank at (wrow, wch)
//   wdat
//   rrow, rdat      CH pixels of row rrow from the front bank, channel 0 in the LSBs
module leddc_fbuf import leddc_pkg::*; #(
    parameter int CH   = 16,
    parameter int GW   = 8,
    parameter int ROWS = 4,
    localparam int RW  = clog2(ROWS),
    localparam int WW  = clog2(CH),
    localparam int AW  = clog2(ROWS * CH)
) (
    input  logic               GCK,
    input  logic               rst,
    input  logic               swap,
    input  logic               we,
    input  logic [RW-1:0]      wrow,
    input  logic [WW-1:0]      wch,
    input  logic [GW-1:0]      wdat,
    input  logic [RW-1:0]      rrow,
    output logic [CH*GW-1:0]   rdat
);

    logic          front_sel;
    logic [GW-1:0] bank0 [ROWS*CH];
    logic [GW-1:0] bank1 [ROWS*CH];
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;

    assign waddr = AW'(wrow) * AW'(CH) + AW'(wch);

    always_ff @(posedge GCK) begin
        if (rst) begin
            front_sel <= 1'b0;
        end else if (swap) begin
            front_sel <= ~front_sel;
        end
    end

    // Contents survive reset; the back bank is whichever one is not in front.
    always_ff @(posedge GCK) begin
        if (we) begin
            if (front_sel) begin
                bank0[waddr] <= wdat;
            end else begin
                bank1[waddr] <= wdat;
            end
        end
    end

    always_comb begin
        rdat  = '0;
        raddr = '0;
        for (int c = 0; c < CH; c++) begin
            raddr = AW'(rrow) * AW'(CH) + AW'(c);
            rdat[c*GW +: GW] = front_sel ? bank1[raddr] : bank0[raddr];
        end
    end

endmodule

// File: rtl/leddc_scan_pwm.sv
// Serial grey-scale loader into a ping-pong frame store plus row-scanned PWM driver.
// Latency: OUT/ROW/FDONE registered, 1 cycle after the scan state that produces them.
// Backpressure: none; DAI bits are dropped while READY is high or on a Vsync rise.
//
// Ports:
//   GCK, rst      clock, synchronous active-high reset
//   DAI, DEN      serial pixel bit (LSB first) and its valid
//   Vsync         display enable; rising edge starts a frame and may swap banks
//   mode          0: GW-bit PWM, 1: (GW-1)-bit PWM with LSB dither (latched at Vsync rise)
//   OUT           CH channel drives
//   ROW           active row index
//   READY         back bank holds a complete frame awaiting a swap
//   FDONE         one-cycle pulse after the last row's PWM phase
module leddc_scan_pwm import leddc_pkg::*; #(
    parameter int CH    = 16,
    parameter int GW    = 8,
    parameter int ROWS  = 4,
    parameter int BLANK = 2,
    localparam int RW   = clog2(ROWS)
) (
    input  logic          GCK,
    input  logic          rst,
    input  logic          DAI,
    input  logic          DEN,
    input  logic          Vsync,
    input  logic          mode,
    output logic [CH-1:0] OUT,
    output logic [RW-1:0] ROW,
    output logic          READY,
    output logic          FDONE
);

    localparam int WW = clog2(CH);
    localparam int BW = clog2(GW);
    // Phase counter covers both the blanking interval and the longest PWM phase.
    localparam int CW = (clog2(BLANK) > GW) ? clog2(BLANK) : GW;

    // ---------------------------------------------------------------- write side
    logic          vs_q;
    logic          vs_rise;
    logic [BW-1:0] bitcnt;
    logic [GW-1:0] pix;
    logic [GW-1:0] wr_pix;
    logic [RW-1:0] wrow;
    logic [WW-1:0] wch;
    logic          take_bit;
    logic          wr_en;
    logic          mode_q;
    logic          round;

    assign vs_rise  = Vsync && !vs_q;
    // A Vsync rise restarts the write pointer, so a bit in that cycle is dropped.
    assign take_bit = DEN && !READY && !vs_rise;
    assign wr_en    = take_bit && (bitcnt == BW'(GW - 1));

    always_comb begin
        wr_pix         = pix;
        wr_pix[bitcnt] = DAI;
    end

    always_ff @(posedge GCK) begin
        if (rst) begin
            vs_q   <= 1'b0;
            bitcnt <= '0;
            pix    <= '0;
            wrow   <= '0;
            wch    <= '0;
            READY  <= 1'b0;
            mode_q <= MODE_FULL;
            round  <= 1'b0;
        end else begin
            vs_q <= Vsync;
            if (vs_rise) begin
                bitcnt <= '0;
                wrow   <= '0;
                wch    <= '0;
                READY  <= 1'b0;
                mode_q <= mode;
                round  <= ~round;
            end else if (take_bit) begin
                pix <= wr_pix;
                if (bitcnt == BW'(GW - 1)) begin
                    bitcnt <= '0;
                    if (wch == WW'(CH - 1)) begin
                        wch <= '0;
                        if (wrow == RW'(ROWS - 1)) begin
                            wrow  <= '0;
                            READY <= 1'b1;
                        end else begin
                            wrow <= wrow + 1'b1;
                        end
                    end else begin
                        wch <= wch + 1'b1;
                    end
                end else begin
                    bitcnt <= bitcnt + 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- frame store
    logic [RW-1:0]    row_idx;
    logic [CH*GW-1:0] row_pix;

    leddc_fbuf #(
        .CH   (CH),
        .GW   (GW),
        .ROWS (ROWS)
    ) u_fbuf (
        .GCK  (GCK),
        .rst  (rst),
        .swap (vs_rise && READY),
        .we   (wr_en),
        .wrow (wrow),
        .wch  (wch),
        .wdat (wr_pix),
        .rrow (row_idx),
        .rdat (row_pix)
    );

    // ---------------------------------------------------------------- scan FSM
    scan_state_e   state;
    scan_state_e   state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] p_last;
    logic [RW-1:0] row_nxt;
    logic [RW-1:0] row_out_nxt;
    logic [CH-1:0] pwm_hit;
    logic [CH-1:0] out_nxt;
    logic          fdone_nxt;

    assign p_last = (mode_q == MODE_HALF) ? CW'((1 << (GW - 1)) - 1)
                                          : CW'((1 << GW) - 1);

    always_comb begin
        pwm_hit = '0;
        for (int c = 0; c < CH; c++) begin
            pwm_hit[c] = cnt < CW'(GW'(duty_calc(32'(row_pix[c*GW +: GW]), mode_q, round)));
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        row_nxt     = row_idx;
        row_out_nxt = ROW;
        out_nxt     = '0;
        fdone_nxt   = 1'b0;
        if (vs_rise) begin
            state_nxt = ST_BLANK;
            cnt_nxt   = '0;
            row_nxt   = '0;
        end else if (!Vsync) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_nxt = ST_IDLE;
                end
                ST_BLANK: begin
                    if (cnt == '0) begin
                        row_out_nxt = row_idx;
                    end
                    if (cnt == CW'(BLANK - 1)) begin
                        state_nxt = ST_PWM;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_PWM: begin
                    out_nxt = pwm_hit;
                    if (cnt == p_last) begin
                        state_nxt = ST_BLANK;
                        cnt_nxt   = '0;
                        if (row_idx == RW'(ROWS - 1)) begin
                            row_nxt   = '0;
                            fdone_nxt = 1'b1;
                        end else begin
                            row_nxt = row_idx + 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge GCK) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            row_idx <= '0;
            OUT     <= '0;
            ROW     <= '0;
            FDONE   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            row_idx <= row_nxt;
            OUT     <= out_nxt;
            ROW     <= row_out_nxt;
            FDONE   <= fdone_nxt;
        end
    end

endmodule
